// File: rtl/uart_rx_fifo_wr.sv
// uart_rx_fifo_wr
//   8N1 UART receiver feeding the write port of the RX FIFO.
//   The line is double-flopped. Each frame is qualified at the start-bit
//   mid-point and then sampled at every following bit mid-point. A good stop
//   bit produces a one-cycle write strobe, or an overrun pulse if the FIFO is
//   full. A low stop bit produces a single frame_err, and the receiver then
//   parks until the line returns high.
//
// Ports
//   clk_i          system clock
//   rst_n_i        synchronous active-low reset
//   rx_i           asynchronous serial line, idle high
//   fifo_full_i    RX FIFO full flag (sampled only at the stop decision)
//   wr_en_o        one-cycle FIFO write strobe per accepted byte
//   wr_data_o      received byte, held until the next write
//   rx_busy_o      high from start detection until the stop decision
//   frame_err_o    one-cycle pulse, stop bit sampled low
//   overrun_err_o  one-cycle pulse, good byte dropped because FIFO was full
module uart_rx_fifo_wr #(
    parameter int CLKS_PER_BIT = 32,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rx_i,
    input  logic       fifo_full_i,
    output logic       wr_en_o,
    output logic [7:0] wr_data_o,
    output logic       rx_busy_o,
    output logic       frame_err_o,
    output logic       overrun_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      sh_q, sh_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            wr_en_q, wr_en_d;
    logic            fe_q, fe_d;
    logic            ov_q, ov_d;
    logic            rx_meta_q, rx_s_q;

    // State register and all datapath flops
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_q      <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        fe_d      = 1'b0;
        ov_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    // A line that is high again at mid-start was a glitch
                    state_d = rx_s_q ? IDLE : DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    sh_d  = {rx_s_q, sh_q[7:1]};   // LSB arrives first
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    // Decide at stop mid-point so a back-to-back start is caught
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                        if (fifo_full_i) begin
                            ov_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_data_d = sh_q;
                        end
                    end else begin
                        fe_d    = 1'b1;
                        state_d = BRK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BRK: begin
                // Held-low line: wait for idle, one frame_err only
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        wr_en_o       = wr_en_q;
        wr_data_o     = wr_data_q;
        frame_err_o   = fe_q;
        overrun_err_o = ov_q;
        rx_busy_o     = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    end

endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// tb_uart_rx_fifo_wr
//   Randomised and directed frames against a frame-level model. Each frame
//   sent schedules its expected outcome (write, frame error, overrun) at the
//   nominal cycle t0+307, and a busy interval. A per-cycle monitor matches
//   DUT pulses against that schedule within +/-1 cycle, and checks wr_data
//   hold and rx_busy away from the interval edges.
module tb_uart_rx_fifo_wr;

    localparam int CPB  = 32;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;   // 307

    logic       clk, rst_n, rx, fifo_full;
    logic       wr_en, rx_busy, frame_err, overrun_err;
    logic [7:0] wr_data;

    uart_rx_fifo_wr #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .rx_i(rx), .fifo_full_i(fifo_full),
        .wr_en_o(wr_en), .wr_data_o(wr_data), .rx_busy_o(rx_busy),
        .frame_err_o(frame_err), .overrun_err_o(overrun_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct { int cyc; int kind; logic [7:0] d; } ev_t;   // kind 1 wr, 2 fe, 3 ov
    typedef struct { int s; int e; } iv_t;

    ev_t evq[$];
    iv_t ivq[$];
    int  checks = 0, errors = 0;
    int  cyc = -1;
    int  rst_cyc = -100;
    int  last_t0 = 0;
    bit  go = 0;
    logic [7:0] last_wr = 8'h00;   // model of wr_data
    logic [7:0] cap_data = 8'h00;  // DUT byte captured on wr_en
    int  cap_cyc = 0, nwr = 0, nfe = 0, nov = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle monitor
    int   m_kind, m_hits, m_dt;
    bit   m_exp_busy, m_uncertain;
    always @(negedge clk) if (go) begin
        if (cyc == rst_cyc) begin
            last_wr = 8'h00;
            chk("rst_wr_en", wr_en, 0);
            chk("rst_wr_data", wr_data, 0);
            chk("rst_busy", rx_busy, 0);
            chk("rst_frame_err", frame_err, 0);
            chk("rst_overrun", overrun_err, 0);
        end
        while (evq.size() > 0 && evq[0].cyc + 1 < cyc) begin
            checks++; errors++;
            $display("FAIL missed_event kind=%0d expected_cyc=%0d data=%h seen=none",
                     evq[0].kind, evq[0].cyc, evq[0].d);
            void'(evq.pop_front());
        end
        m_hits = int'(wr_en) + int'(frame_err) + int'(overrun_err);
        if (m_hits > 0) begin
            chk("single_pulse", m_hits, 1);
            m_kind = wr_en ? 1 : (frame_err ? 2 : 3);
            if (wr_en) begin nwr++; cap_data = wr_data; cap_cyc = cyc; end
            if (frame_err) nfe++;
            if (overrun_err) nov++;
            checks++;
            if (evq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse kind=%0d cyc=%0d expected=nothing", m_kind, cyc);
            end else begin
                m_dt = cyc - evq[0].cyc;
                if (evq[0].kind != m_kind || m_dt > 1 || m_dt < -1) begin
                    errors++;
                    $display("FAIL pulse_match actual kind=%0d cyc=%0d expected kind=%0d cyc=%0d",
                             m_kind, cyc, evq[0].kind, evq[0].cyc);
                    if (m_dt > 1) void'(evq.pop_front());
                end else begin
                    if (m_kind == 1) begin
                        chk("wr_data_on_write", wr_data, evq[0].d);
                        last_wr = evq[0].d;
                    end
                    void'(evq.pop_front());
                end
            end
        end
        if (!wr_en) chk("wr_data_hold", wr_data, last_wr);
        m_exp_busy = 0; m_uncertain = 0;
        foreach (ivq[i]) begin
            if (cyc >= ivq[i].s && cyc < ivq[i].e) m_exp_busy = 1;
            if ((cyc - ivq[i].s) <= 1 && (ivq[i].s - cyc) <= 1) m_uncertain = 1;
            if ((cyc - ivq[i].e) <= 1 && (ivq[i].e - cyc) <= 1) m_uncertain = 1;
        end
        if (!m_uncertain) chk("rx_busy", rx_busy, m_exp_busy);
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame starting at the next posedge. stop=0 forces a low stop
    // bit, tail_low extends the low line after it, rst_at>=0 pulses reset
    // at that cycle offset (aborting the frame).
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit full,
                              input int tail_low, input int rst_at);
        logic [9:0] fr;
        int t0;
        ev_t e;
        iv_t iv;
        fr = {stop, b, 1'b0};
        t0 = cyc + 1;
        last_t0 = t0;
        fifo_full = full;
        iv.s = t0 + 2;
        iv.e = (rst_at >= 0) ? t0 + rst_at : t0 + LAT;
        ivq.push_back(iv);
        if (rst_at >= 0) begin
            rst_cyc = t0 + rst_at;
        end else begin
            e.cyc = t0 + LAT;
            e.d   = b;
            e.kind = !stop ? 2 : (full ? 3 : 1);
            evq.push_back(e);
        end
        for (int j = 0; j < 10 * CPB; j++) begin
            rx    = fr[j / CPB];
            rst_n = (j == rst_at) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b1;
        if (tail_low > 0) begin
            rx = 1'b0;
            repeat (tail_low) @(negedge clk);
            rx = 1'b1;
        end
    endtask

    int base_wr, t_a;

    initial begin
        rst_n = 1'b0; rx = 1'b1; fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_wr_en", wr_en, 0);
        chk("init_wr_data", wr_data, 0);
        chk("init_busy", rx_busy, 0);
        chk("init_fe", frame_err, 0);
        chk("init_ov", overrun_err, 0);
        rst_n = 1'b1;
        go = 1;
        idle(20);

        // single 0x55
        send_frame(8'h55, 1, 0, 0, -1);
        idle(40);
        chk("pin_first_count", nwr, 1);
        chk("pin_first_data", cap_data, 8'h55);
        checks++;
        if (cap_cyc - last_t0 < 306 || cap_cyc - last_t0 > 308) begin
            errors++;
            $display("FAIL pin_latency actual=%0d expected=307+/-1", cap_cyc - last_t0);
        end

        // back-to-back A3, 0F, FF
        base_wr = nwr;
        send_frame(8'hA3, 1, 0, 0, -1);
        t_a = last_t0;
        send_frame(8'h0F, 1, 0, 0, -1);
        send_frame(8'hFF, 1, 0, 0, -1);
        idle(40);
        chk("pin_b2b_count", nwr - base_wr, 3);
        chk("pin_b2b_last", cap_data, 8'hFF);
        checks++;
        if (cap_cyc - t_a < 946 || cap_cyc - t_a > 948) begin
            errors++;
            $display("FAIL pin_b2b_spacing actual=%0d expected=947+/-1", cap_cyc - t_a);
        end

        // 8-clock glitch
        begin
            iv_t iv;
            iv.s = cyc + 3; iv.e = cyc + 1 + 18;
            ivq.push_back(iv);
            rx = 1'b0;
            repeat (8) @(negedge clk);
            idle(60);
        end

        // stop low, line held low 1000 clocks, then 0x81
        send_frame(8'h3C, 0, 0, 1000, -1);
        idle(30);
        chk("pin_break_fe", nfe, 1);
        send_frame(8'h81, 1, 0, 0, -1);
        idle(30);
        chk("pin_after_break", cap_data, 8'h81);

        // overrun on 0x77, then 0x12 written
        send_frame(8'h77, 1, 1, 0, -1);
        idle(30);
        chk("pin_overrun", nov, 1);
        chk("pin_overrun_hold", wr_data, 8'h81);
        send_frame(8'h12, 1, 0, 0, -1);
        idle(30);

        // reset in the middle of 0xC4 (during data bit 6, line high to the end)
        base_wr = nwr;
        send_frame(8'hC4, 1, 0, 0, 7 * CPB + HALF);
        idle(30);
        chk("pin_rst_nowrite", nwr - base_wr, 0);
        send_frame(8'h5A, 1, 0, 0, -1);
        idle(30);
        chk("pin_after_rst", cap_data, 8'h5A);

        // random frames, random gaps and fifo_full, occasional bad stop
        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            bit st, fl;
            int tl;
            b  = 8'($urandom);
            fl = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 5) != 0);
            tl = st ? 0 : $urandom_range(10, 60);
            send_frame(b, st, fl, tl, -1);
            idle($urandom_range(0, 40));
        end

        idle(400);
        chk("queue_drained", evq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
